// File: rtl/mrbuf_ctrl.sv
// mrbuf_ctrl - sequencing controller for a multi-rate circular buffer.
//
// The producer writes bursts of K words and the consumer reads bursts of
// J words. A single memory port is shared between them. Each burst runs
// to completion. The pointers and occupancy commit on the edge after the
// last beat.
//
// Parameters:
//   AW  address width; buffer depth is 2**AW
//   K   words per write burst (1..DEPTH)
//   J   words per read burst  (1..DEPTH)
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wr_req, rd_req      level requests for one burst
//   wr_grant, rd_grant  high on every beat of a write / read burst
//   wr_done, rd_done    pulse on the last beat of a burst
//   mem_we, mem_addr    memory port controls
//   wr_ptr, rd_ptr      committed pointers
//   count               committed occupancy, 0..DEPTH
//   full, empty         a write / read burst cannot currently proceed
//
// Optional build macro MRBUF_ERR_EN adds sticky wr_err / rd_err flags.
// wr_err is set by a write request that is refused because the buffer is
// full. rd_err is set by a read request that is refused because it is empty.

module mrbuf_ctrl #(
  parameter int AW = 4,
  parameter int K  = 4,
  parameter int J  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_grant,
  output logic          rd_grant,
  output logic          wr_done,
  output logic          rd_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
`ifdef MRBUF_ERR_EN
  ,
  output logic          wr_err,
  output logic          rd_err
`endif
);

  localparam int DEPTH = 2**AW;

  localparam logic [AW-1:0] K_LAST = AW'(K - 1);
  localparam logic [AW-1:0] J_LAST = AW'(J - 1);
  // When the burst length equals DEPTH, the pointer step truncates to 0.
  // A full-buffer burst therefore returns the pointer to where it started.
  localparam logic [AW-1:0] K_PTR  = AW'(K);
  localparam logic [AW-1:0] J_PTR  = AW'(J);
  localparam logic [AW:0]   K_CNT  = (AW+1)'(K);
  localparam logic [AW:0]   J_CNT  = (AW+1)'(J);
  localparam logic [AW:0]   D_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t        state;
  logic [AW-1:0] beat;
  logic          prio;   // 0: write wins a tie, 1: read wins
  logic          ew, er;

  // count never exceeds DEPTH, so the subtraction cannot wrap.
  assign full  = (D_CNT - count) < K_CNT;
  assign empty = count < J_CNT;

  assign ew = wr_req & ~full;
  assign er = rd_req & ~empty;

  // The beat outputs are registered. The first beat is therefore loaded on
  // the edge that leaves IDLE. Each later beat is loaded from beat+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      prio     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_grant <= 1'b0;
      rd_grant <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (ew && (!er || !prio)) begin
            state    <= WR_BURST;
            wr_grant <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= wr_ptr;
            wr_done  <= (K == 1);
          end else if (er) begin
            state    <= RD_BURST;
            rd_grant <= 1'b1;
            mem_addr <= rd_ptr;
            rd_done  <= (J == 1);
          end
        end

        WR_BURST: begin
          if (beat == K_LAST) begin
            state    <= IDLE;
            wr_ptr   <= wr_ptr + K_PTR;
            count    <= count + K_CNT;
            prio     <= 1'b1;
            wr_grant <= 1'b0;
            mem_we   <= 1'b0;
            wr_done  <= 1'b0;
            mem_addr <= '0;
          end else begin
            beat     <= beat + AW'(1);
            mem_addr <= wr_ptr + beat + AW'(1);
            wr_done  <= ((beat + AW'(1)) == K_LAST);
          end
        end

        RD_BURST: begin
          if (beat == J_LAST) begin
            state    <= IDLE;
            rd_ptr   <= rd_ptr + J_PTR;
            count    <= count - J_CNT;
            prio     <= 1'b0;
            rd_grant <= 1'b0;
            rd_done  <= 1'b0;
            mem_addr <= '0;
          end else begin
            beat     <= beat + AW'(1);
            mem_addr <= rd_ptr + beat + AW'(1);
            rd_done  <= ((beat + AW'(1)) == J_LAST);
          end
        end

        default: begin
          state    <= IDLE;
          wr_grant <= 1'b0;
          rd_grant <= 1'b0;
          wr_done  <= 1'b0;
          rd_done  <= 1'b0;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MRBUF_ERR_EN
  // Requests are only sampled in IDLE. A refused request outside IDLE is
  // therefore not an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else if (state == IDLE) begin
      if (wr_req && full)  wr_err <= 1'b1;
      if (rd_req && empty) rd_err <= 1'b1;
    end
  end
`endif

endmodule
